// File: rtl/m_mem_arb_if.sv
// Bundles the fetch port, the load/store port and the shared memory port of m_mem_arb.
// Latency: none; wires only.
// Backpressure: req/done handshake towards the pipeline, req/ack handshake towards memory.
interface m_mem_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              w_if_req;
    logic [ADDR_W-1:0] w_if_addr;
    logic [DATA_W-1:0] w_if_rdata;
    logic              w_if_done;

    logic              w_d_req;
    logic              w_d_we;
    logic [ADDR_W-1:0] w_d_addr;
    logic [DATA_W-1:0] w_d_wdata;
    logic [DATA_W-1:0] w_d_rdata;
    logic              w_d_done;

    logic              w_m_req;
    logic              w_m_we;
    logic [ADDR_W-1:0] w_m_addr;
    logic [DATA_W-1:0] w_m_wdata;
    logic [DATA_W-1:0] w_m_rdata;
    logic              w_m_ack;

    logic              w_stall;

    // Arbiter side
    modport master (
        input  w_if_req, w_if_addr,
        output w_if_rdata, w_if_done,
        input  w_d_req, w_d_we, w_d_addr, w_d_wdata,
        output w_d_rdata, w_d_done,
        output w_m_req, w_m_we, w_m_addr, w_m_wdata,
        input  w_m_rdata, w_m_ack,
        output w_stall
    );

    // Pipeline + memory side
    modport slave (
        output w_if_req, w_if_addr,
        input  w_if_rdata, w_if_done,
        output w_d_req, w_d_we, w_d_addr, w_d_wdata,
        input  w_d_rdata, w_d_done,
        input  w_m_req, w_m_we, w_m_addr, w_m_wdata,
        output w_m_rdata, w_m_ack,
        input  w_stall
    );
endinterface

// File: rtl/m_mem_arb.sv
// Shares one single-port memory between instruction fetch and load/store, data first.
// Latency: 3 cycles minimum per access (IDLE grant, BUSY until ack, RESP done pulse).
// Backpressure: requesters hold req until done; w_stall freezes the pipeline meanwhile.
module m_mem_arb #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic w_clk,
    input  logic w_rst_n,
    m_mem_arb_if.master mem_bus
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              grant_d;
    logic              grant_f;
    logic              starving;
    logic              ack_take;

    logic              owner_q;      // 1 = data port owns the memory
    logic [3:0]        starve_q;
    logic              m_req_q;
    logic              m_we_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [DATA_W-1:0] m_wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              if_done_q;
    logic              d_done_q;

    assign starving = mem_bus.w_if_req && (starve_q == STARVE_LIM);
    assign ack_take = (state_q == BUSY) && mem_bus.w_m_ack;

    always_comb begin
        state_d = state_q;
        grant_d = 1'b0;
        grant_f = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_bus.w_d_req && !starving) begin
                    grant_d = 1'b1;
                    state_d = BUSY;
                end else if (mem_bus.w_if_req) begin
                    grant_f = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (mem_bus.w_m_ack) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Memory-port registers: loaded on grant, held through BUSY, req dropped on first ack.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            owner_q   <= 1'b0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
        end else if (grant_d) begin
            owner_q   <= 1'b1;
            m_req_q   <= 1'b1;
            m_we_q    <= mem_bus.w_d_we;
            m_addr_q  <= mem_bus.w_d_addr;
            m_wdata_q <= mem_bus.w_d_wdata;
        end else if (grant_f) begin
            owner_q   <= 1'b0;
            m_req_q   <= 1'b1;
            m_we_q    <= 1'b0;
            m_addr_q  <= mem_bus.w_if_addr;
            m_wdata_q <= '0;
        end else if (ack_take) begin
            m_req_q   <= 1'b0;
        end
    end

    // Response registers: only the owner's rdata moves; done lasts exactly the RESP cycle.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
        end else begin
            if_done_q <= ack_take && !owner_q;
            d_done_q  <= ack_take && owner_q;
            if (ack_take && owner_q) begin
                d_rdata_q <= mem_bus.w_m_rdata;
            end
            if (ack_take && !owner_q) begin
                if_rdata_q <= mem_bus.w_m_rdata;
            end
        end
    end

    // Counts data grants that overtook a waiting fetch.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            starve_q <= '0;
        end else if (grant_f) begin
            starve_q <= '0;
        end else if (grant_d && mem_bus.w_if_req) begin
            if (starve_q != STARVE_LIM) begin
                starve_q <= starve_q + 4'd1;
            end
        end else if ((state_q == IDLE) && !mem_bus.w_if_req) begin
            starve_q <= '0;
        end
    end

    assign mem_bus.w_m_req    = m_req_q;
    assign mem_bus.w_m_we     = m_we_q;
    assign mem_bus.w_m_addr   = m_addr_q;
    assign mem_bus.w_m_wdata  = m_wdata_q;
    assign mem_bus.w_if_rdata = if_rdata_q;
    assign mem_bus.w_if_done  = if_done_q;
    assign mem_bus.w_d_rdata  = d_rdata_q;
    assign mem_bus.w_d_done   = d_done_q;
    assign mem_bus.w_stall    = (mem_bus.w_if_req && !if_done_q) ||
                                (mem_bus.w_d_req && !d_done_q);

endmodule

// File: tb/tb_m_mem_arb.sv
// Directed bench for m_mem_arb: inputs change and outputs are checked on the falling edge.
// Each scenario task carries its own hand-computed expectations.
module tb_m_mem_arb;

    logic w_clk;
    logic w_rst_n;
    int   n_cmp;
    int   n_err;

    m_mem_arb_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    m_mem_arb #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .w_clk   (w_clk),
        .w_rst_n (w_rst_n),
        .mem_bus (bus)
    );

    initial begin
        w_clk = 1'b0;
        forever #5 w_clk = ~w_clk;
    end

    task automatic cyc();
        @(negedge w_clk);
    endtask

    task automatic test_reset();
        w_rst_n = 1'b0;
        bus.w_if_req = 0; bus.w_if_addr = '0;
        bus.w_d_req = 0; bus.w_d_we = 0; bus.w_d_addr = '0; bus.w_d_wdata = '0;
        bus.w_m_ack = 0; bus.w_m_rdata = '0;
        cyc(); cyc();
        n_cmp++;
        if ({bus.w_m_req, bus.w_m_we, bus.w_m_addr, bus.w_m_wdata} !== 66'd0) begin
            n_err++; $display("FAIL reset_mport: got %h want 0", {bus.w_m_req, bus.w_m_we, bus.w_m_addr, bus.w_m_wdata});
        end
        n_cmp++;
        if ({bus.w_if_done, bus.w_d_done, bus.w_if_rdata, bus.w_d_rdata, bus.w_stall} !== 67'd0) begin
            n_err++; $display("FAIL reset_resp: got %h want 0", {bus.w_if_done, bus.w_d_done, bus.w_if_rdata, bus.w_d_rdata});
        end
        w_rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_single_load();
        bus.w_d_req = 1; bus.w_d_we = 0; bus.w_d_addr = 32'h40;
        cyc();
        n_cmp++;
        if ({bus.w_m_req, bus.w_m_we, bus.w_m_addr} !== {1'b1, 1'b0, 32'h40}) begin
            n_err++; $display("FAIL load_busy: got req/we/addr %b/%b/%h want 1/0/00000040", bus.w_m_req, bus.w_m_we, bus.w_m_addr);
        end
        n_cmp++;
        if ({bus.w_stall, bus.w_d_done} !== 2'b10) begin
            n_err++; $display("FAIL load_stall1: got stall/done %b/%b want 1/0", bus.w_stall, bus.w_d_done);
        end
        cyc();
        n_cmp++;
        if ({bus.w_m_req, bus.w_m_addr, bus.w_stall} !== {1'b1, 32'h40, 1'b1}) begin
            n_err++; $display("FAIL load_busy2: got req/addr/stall %b/%h/%b want 1/00000040/1", bus.w_m_req, bus.w_m_addr, bus.w_stall);
        end
        bus.w_m_ack = 1; bus.w_m_rdata = 32'hDEADBEEF;
        cyc();
        n_cmp++;
        if ({bus.w_d_done, bus.w_d_rdata} !== {1'b1, 32'hDEADBEEF}) begin
            n_err++; $display("FAIL load_done: got done/rdata %b/%h want 1/deadbeef", bus.w_d_done, bus.w_d_rdata);
        end
        n_cmp++;
        if ({bus.w_m_req, bus.w_stall, bus.w_if_done} !== 3'b000) begin
            n_err++; $display("FAIL load_resp: got req/stall/if_done %b/%b/%b want 0/0/0", bus.w_m_req, bus.w_stall, bus.w_if_done);
        end
        bus.w_m_ack = 0; bus.w_d_req = 0;
        cyc();
        n_cmp++;
        if ({bus.w_d_done, bus.w_m_req} !== 2'b00) begin
            n_err++; $display("FAIL load_pulse: got done/req %b/%b want 0/0", bus.w_d_done, bus.w_m_req);
        end
    endtask

    task automatic test_store();
        bus.w_d_req = 1; bus.w_d_we = 1; bus.w_d_addr = 32'h80; bus.w_d_wdata = 32'h12345678;
        cyc();
        n_cmp++;
        if ({bus.w_m_req, bus.w_m_we, bus.w_m_addr, bus.w_m_wdata} !== {1'b1, 1'b1, 32'h80, 32'h12345678}) begin
            n_err++; $display("FAIL store_busy: got we/addr/wdata %b/%h/%h want 1/00000080/12345678", bus.w_m_we, bus.w_m_addr, bus.w_m_wdata);
        end
        bus.w_d_addr = 32'h999; bus.w_d_wdata = 32'hFFFF0000; bus.w_d_we = 0;
        cyc();
        n_cmp++;
        if ({bus.w_m_we, bus.w_m_addr, bus.w_m_wdata} !== {1'b1, 32'h80, 32'h12345678}) begin
            n_err++; $display("FAIL store_hold: got we/addr/wdata %b/%h/%h want 1/00000080/12345678", bus.w_m_we, bus.w_m_addr, bus.w_m_wdata);
        end
        bus.w_m_ack = 1; bus.w_m_rdata = 32'hA5A5A5A5;
        cyc();
        n_cmp++;
        if ({bus.w_d_done, bus.w_if_done} !== 2'b10) begin
            n_err++; $display("FAIL store_done: got d_done/if_done %b/%b want 1/0", bus.w_d_done, bus.w_if_done);
        end
        bus.w_m_ack = 0; bus.w_d_req = 0;
        cyc();
        n_cmp++;
        if ({bus.w_d_done, bus.w_if_done} !== 2'b00) begin
            n_err++; $display("FAIL store_pulse: got d_done/if_done %b/%b want 0/0", bus.w_d_done, bus.w_if_done);
        end
    endtask

    task automatic test_simultaneous();
        bus.w_if_req = 1; bus.w_if_addr = 32'h0;
        bus.w_d_req = 1; bus.w_d_we = 0; bus.w_d_addr = 32'h100;
        cyc();
        n_cmp++;
        if ({bus.w_m_req, bus.w_m_we, bus.w_m_addr} !== {1'b1, 1'b0, 32'h100}) begin
            n_err++; $display("FAIL sim_first: got req/we/addr %b/%b/%h want 1/0/00000100", bus.w_m_req, bus.w_m_we, bus.w_m_addr);
        end
        bus.w_m_ack = 1; bus.w_m_rdata = 32'h11111111;
        cyc();
        n_cmp++;
        if ({bus.w_d_done, bus.w_if_done, bus.w_stall, bus.w_d_rdata} !== {3'b101, 32'h11111111}) begin
            n_err++; $display("FAIL sim_d_done: got d/if/stall %b/%b/%b rdata %h want 1/0/1 11111111", bus.w_d_done, bus.w_if_done, bus.w_stall, bus.w_d_rdata);
        end
        bus.w_m_ack = 0; bus.w_d_req = 0;
        cyc();
        cyc();
        n_cmp++;
        if ({bus.w_m_req, bus.w_m_we, bus.w_m_addr} !== {1'b1, 1'b0, 32'h0}) begin
            n_err++; $display("FAIL sim_second: got req/we/addr %b/%b/%h want 1/0/00000000", bus.w_m_req, bus.w_m_we, bus.w_m_addr);
        end
        bus.w_m_ack = 1; bus.w_m_rdata = 32'h22222222;
        cyc();
        n_cmp++;
        if ({bus.w_if_done, bus.w_d_done, bus.w_if_rdata, bus.w_d_rdata} !== {2'b10, 32'h22222222, 32'h11111111}) begin
            n_err++; $display("FAIL sim_if_done: got if/d %b/%b if_rdata %h d_rdata %h want 1/0 22222222 11111111", bus.w_if_done, bus.w_d_done, bus.w_if_rdata, bus.w_d_rdata);
        end
        bus.w_m_ack = 0; bus.w_if_req = 0;
        cyc();
        n_cmp++;
        if ({bus.w_if_done, bus.w_stall} !== 2'b00) begin
            n_err++; $display("FAIL sim_end: got if_done/stall %b/%b want 0/0", bus.w_if_done, bus.w_stall);
        end
    endtask

    task automatic test_starvation();
        logic [31:0] exp_addr [6];
        exp_addr = '{32'h300, 32'h300, 32'h300, 32'h300, 32'h200, 32'h300};
        bus.w_if_req = 1; bus.w_if_addr = 32'h200;
        bus.w_d_req = 1; bus.w_d_we = 0; bus.w_d_addr = 32'h300;
        for (int g = 0; g < 6; g++) begin
            cyc();
            n_cmp++;
            if ({bus.w_m_req, bus.w_m_addr} !== {1'b1, exp_addr[g]}) begin
                n_err++; $display("FAIL starve_grant%0d: got req/addr %b/%h want 1/%h", g, bus.w_m_req, bus.w_m_addr, exp_addr[g]);
            end
            bus.w_m_ack = 1; bus.w_m_rdata = 32'h1000 + 32'(g);
            cyc();
            n_cmp++;
            if ({bus.w_if_done, bus.w_d_done} !== ((g == 4) ? 2'b10 : 2'b01)) begin
                n_err++; $display("FAIL starve_done%0d: got if/d %b/%b want %b", g, bus.w_if_done, bus.w_d_done, (g == 4) ? 2'b10 : 2'b01);
            end
            bus.w_m_ack = 0;
            cyc();
            if (g == 5) begin
                bus.w_if_req = 0; bus.w_d_req = 0;
            end
        end
        cyc();
        n_cmp++;
        if (bus.w_m_req !== 1'b0) begin
            n_err++; $display("FAIL starve_quiet: got req %b want 0", bus.w_m_req);
        end
    endtask

    task automatic test_reset_mid();
        bus.w_d_req = 1; bus.w_d_we = 0; bus.w_d_addr = 32'h44;
        cyc();
        n_cmp++;
        if ({bus.w_m_req, bus.w_m_addr} !== {1'b1, 32'h44}) begin
            n_err++; $display("FAIL rst_busy: got req/addr %b/%h want 1/00000044", bus.w_m_req, bus.w_m_addr);
        end
        #2 w_rst_n = 1'b0;
        bus.w_d_req = 0;
        #1;
        n_cmp++;
        if ({bus.w_m_req, bus.w_m_addr, bus.w_d_done, bus.w_d_rdata} !== 66'd0) begin
            n_err++; $display("FAIL rst_async: got req/addr %b/%h done/rdata %b/%h want all 0", bus.w_m_req, bus.w_m_addr, bus.w_d_done, bus.w_d_rdata);
        end
        cyc();
        w_rst_n = 1'b1;
        bus.w_m_ack = 1; bus.w_m_rdata = 32'hCAFECAFE;
        cyc();
        n_cmp++;
        if ({bus.w_m_req, bus.w_d_done, bus.w_if_done, bus.w_d_rdata} !== 35'd0) begin
            n_err++; $display("FAIL rst_late_ack: got req/d/if %b/%b/%b rdata %h want 0/0/0 0", bus.w_m_req, bus.w_d_done, bus.w_if_done, bus.w_d_rdata);
        end
        cyc();
        n_cmp++;
        if ({bus.w_m_req, bus.w_d_done} !== 2'b00) begin
            n_err++; $display("FAIL rst_late_ack2: got req/done %b/%b want 0/0", bus.w_m_req, bus.w_d_done);
        end
        bus.w_m_ack = 0;
        bus.w_d_req = 1; bus.w_d_addr = 32'h48;
        cyc();
        n_cmp++;
        if ({bus.w_m_req, bus.w_m_addr} !== {1'b1, 32'h48}) begin
            n_err++; $display("FAIL rst_next_req: got req/addr %b/%h want 1/00000048", bus.w_m_req, bus.w_m_addr);
        end
        bus.w_m_ack = 1; bus.w_m_rdata = 32'h5555AAAA;
        cyc();
        n_cmp++;
        if ({bus.w_d_done, bus.w_d_rdata} !== {1'b1, 32'h5555AAAA}) begin
            n_err++; $display("FAIL rst_next_done: got done/rdata %b/%h want 1/5555aaaa", bus.w_d_done, bus.w_d_rdata);
        end
        bus.w_m_ack = 0; bus.w_d_req = 0;
        cyc();
    endtask

    task automatic test_long_ack();
        bus.w_if_req = 1; bus.w_if_addr = 32'h10;
        cyc();
        n_cmp++;
        if ({bus.w_m_req, bus.w_m_we, bus.w_m_addr} !== {1'b1, 1'b0, 32'h10}) begin
            n_err++; $display("FAIL long_busy: got req/we/addr %b/%b/%h want 1/0/00000010", bus.w_m_req, bus.w_m_we, bus.w_m_addr);
        end
        bus.w_m_ack = 1; bus.w_m_rdata = 32'h77777777;
        cyc();
        n_cmp++;
        if ({bus.w_if_done, bus.w_if_rdata} !== {1'b1, 32'h77777777}) begin
            n_err++; $display("FAIL long_done: got done/rdata %b/%h want 1/77777777", bus.w_if_done, bus.w_if_rdata);
        end
        bus.w_if_req = 0;
        for (int c = 0; c < 2; c++) begin
            cyc();
            n_cmp++;
            if ({bus.w_if_done, bus.w_d_done, bus.w_m_req} !== 3'b000) begin
                n_err++; $display("FAIL long_held%0d: got if/d/req %b/%b/%b want 0/0/0", c, bus.w_if_done, bus.w_d_done, bus.w_m_req);
            end
        end
        bus.w_m_ack = 0;
        cyc();
        bus.w_m_ack = 1; bus.w_m_rdata = 32'h00000BAD;
        cyc();
        n_cmp++;
        if ({bus.w_m_req, bus.w_if_done, bus.w_d_done, bus.w_if_rdata, bus.w_d_rdata} !== {3'b000, 32'h77777777, 32'h5555AAAA}) begin
            n_err++; $display("FAIL spurious_ack: got req/if/d %b/%b/%b rdata %h/%h want 0/0/0 77777777/5555aaaa", bus.w_m_req, bus.w_if_done, bus.w_d_done, bus.w_if_rdata, bus.w_d_rdata);
        end
        bus.w_m_ack = 0;
        cyc();
        n_cmp++;
        if ({bus.w_m_req, bus.w_if_done, bus.w_d_done} !== 3'b000) begin
            n_err++; $display("FAIL spurious_after: got req/if/d %b/%b/%b want 0/0/0", bus.w_m_req, bus.w_if_done, bus.w_d_done);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single_load();
        test_store();
        test_simultaneous();
        test_starvation();
        test_reset_mid();
        test_long_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/m_mem_arb.md
Name: m_mem_arb

Overview:
- Arbiter and sequencer that shares one unified single-port memory between the processor's instruction-fetch port and its load/store port.
- Sits between the pipeline (fetch address from the PC register; data address and write data from the ALU/register-file stage) and one external memory with a req/ack handshake.
- Produces per-requester done pulses and stall flags that the pipeline uses to freeze the PC and pipeline registers.
- Data accesses have priority. A bounded starvation counter guarantees fetch progress.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_MAX, 4, maximum consecutive data grants while fetch is waiting; range 1..15.

Ports:
- w_clk  input  1  clock; all state updates on posedge.
- w_rst_n  input  1  asynchronous active-low reset.
- w_if_req  input  1  fetch request; held until w_if_done.
- w_if_addr  input  ADDR_W  fetch address.
- w_if_rdata  output  DATA_W  fetched instruction; valid while w_if_done=1.
- w_if_done  output  1  one-cycle fetch-complete pulse.
- w_d_req  input  1  data request; held until w_d_done.
- w_d_we  input  1  1=store, 0=load.
- w_d_addr  input  ADDR_W  data address.
- w_d_wdata  input  DATA_W  store data.
- w_d_rdata  output  DATA_W  load data; valid while w_d_done=1.
- w_d_done  output  1  one-cycle data-complete pulse.
- w_m_req  output  1  memory request.
- w_m_we  output  1  memory write enable.
- w_m_addr  output  ADDR_W  memory address.
- w_m_wdata  output  DATA_W  memory write data.
- w_m_rdata  input  DATA_W  memory read data; valid with w_m_ack.
- w_m_ack  input  1  memory completion; may be high for one or more cycles.
- w_stall  output  1  pipeline stall: (w_if_req & ~w_if_done) | (w_d_req & ~w_d_done).

Behaviour:
- Reset is asynchronous, active-low.
  - State goes to IDLE.
  - Starvation counter, owner register, and all registered outputs (w_m_*, *_rdata, *_done) clear to 0.
  - An in-flight transaction is abandoned with no done pulse. Any w_m_ack arriving after reset is ignored.
- FSM states are IDLE, BUSY and RESP.
- IDLE:
  - No request pending: stay in IDLE, w_m_req=0.
  - w_d_req=1 and not starving: grant data.
  - Starving is defined as w_if_req=1 and counter==STARVE_MAX. When starving, or when only w_if_req=1: grant fetch.
  - On grant, latch owner, addr, we and wdata into the w_m_* registers, then go to BUSY. A fetch grant forces w_m_we=0.
- BUSY:
  - w_m_req=1; w_m_addr, w_m_we and w_m_wdata are held stable.
  - Stay in BUSY until w_m_ack=1.
  - On the first ack cycle: capture w_m_rdata into the owner's rdata register, drop w_m_req on the next edge, go to RESP.
- RESP:
  - Owner's done=1 for exactly one cycle, with rdata valid. Then go to IDLE.
  - The non-owner's rdata register keeps its previous value.
  - For a store, rdata is updated with whatever w_m_rdata held at ack (don't-care to the pipeline).
- w_m_ack while in IDLE or RESP (including an ack held high across multiple cycles): ignored, no effect.
- Latency: request seen in IDLE at cycle 0 → w_m_req=1 at cycle 1. With ack at cycle k≥1, done=1 at cycle k+1 and IDLE at cycle k+2. Minimum is 3 cycles per access. Back-to-back grants are permitted, with no idle bubble beyond the IDLE cycle.
- A requester updates or drops its req on the edge where its done is high. A req still high in IDLE is a new request.
- Dropping req before done does not abort. The access completes and done still pulses.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) on each data grant made while w_if_req=1.
  - Clears on every fetch grant and in any IDLE cycle with w_if_req=0.
- Request inputs are sampled only in IDLE. Address and data changes during BUSY do not affect the memory port.

Test Plan:
- Single load:
  - Stimulus: w_d_req=1, w_d_we=0, w_d_addr=0x40; memory acks 2 cycles after w_m_req with rdata 0xDEADBEEF.
  - Required: w_m_addr=0x40 and w_m_we=0 while BUSY; w_d_done single-cycle pulse with w_d_rdata=0xDEADBEEF; w_stall=1 until that cycle.
- Store:
  - Stimulus: w_d_we=1, addr 0x80, wdata 0x12345678.
  - Required: w_m_we=1 and w_m_wdata=0x12345678 stable through BUSY; w_d_done pulses once; w_if_done stays 0.
- Simultaneous requests:
  - Stimulus: w_if_req=1 addr 0x0 and w_d_req=1 addr 0x100 in the same cycle.
  - Required: data granted first (w_m_addr=0x100); fetch granted in the next IDLE (w_m_addr=0x0); two separate done pulses.
- Starvation:
  - Stimulus: w_d_req re-asserted continuously, w_if_req held, STARVE_MAX=4.
  - Required: exactly 4 data grants, then one fetch grant, then data resumes.
- Reset mid-op:
  - Stimulus: drive w_rst_n=0 while BUSY, release, then assert w_m_ack.
  - Required: all outputs 0 immediately on reset; no done pulse; the late ack is ignored; the next request proceeds normally.
- Long/spurious ack:
  - Stimulus: w_m_ack held high 3 cycles; a separate ack pulse while IDLE with no requests.
  - Required: exactly one done per transaction; no grant or state change from the spurious ack.
